// File: rtl/filter_pkg.sv
// filter_pkg: shared widths, geometry helpers and pad-generator state encoding.
package filter_pkg;
  localparam int PIXEL_W = 24;
  localparam int CNT_W = 13;
  typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOT} state_t;
  function automatic int boundary_width(input int kernel_size);
    return (kernel_size - 1) / 2;
  endfunction
  function automatic int row_depth(input int width, input int kernel_size);
    return width + 2 * boundary_width(kernel_size);
  endfunction
endpackage

// File: rtl/filter_pad_cnt.sv
// filter_pad_cnt: column/row counter pair with terminal-count flags; row advances on column wrap.
module filter_pad_cnt
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             col_en,
  input  logic             row_en,
  input  logic [CNT_W-1:0] col_max,
  input  logic [CNT_W-1:0] row_max,
  output logic             col_tc,
  output logic             row_tc
);
  logic [CNT_W-1:0] col, row;
  assign col_tc = col == col_max;
  assign row_tc = row == row_max;
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (col_en) begin
      col <= col_tc ? '0 : col + 1'b1;
      if (col_tc && row_en) row <= row_tc ? '0 : row + 1'b1;
    end
  end
endmodule

// File: rtl/filter_pad_gen.sv
// filter_pad_gen: wraps a raw RGB888 frame in a zero border plus flush rows for the FIFO filters.
module filter_pad_gen
  import filter_pkg::*;
#(
  parameter int width       = 320,
  parameter int height      = 240,
  parameter int kernel_size = 7,
  parameter int flush_rows  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iValid,
  input  logic [PIXEL_W-1:0] iData,
  output logic               oReady,
  output logic               oValid,
  output logic [PIXEL_W-1:0] oData,
  output logic               oDone
);
  localparam int bw       = boundary_width(kernel_size);
  localparam int row_dep  = row_depth(width, kernel_size);
  localparam int top_rows = bw;
  localparam int bot_rows = bw + flush_rows;
  localparam logic [CNT_W-1:0] rd_m  = CNT_W'(row_dep - 1);
  localparam logic [CNT_W-1:0] bw_m  = CNT_W'(bw - 1);
  localparam logic [CNT_W-1:0] w_m   = CNT_W'(width - 1);
  localparam logic [CNT_W-1:0] h_m   = CNT_W'(height - 1);
  localparam logic [CNT_W-1:0] top_m = CNT_W'(top_rows - 1);
  localparam logic [CNT_W-1:0] bot_m = CNT_W'(bot_rows - 1);
  state_t state, nxt;
  logic col_en, row_en, col_tc, row_tc, last;
  logic [CNT_W-1:0] col_max, row_max;
  logic nxt_valid, nxt_done;
  logic [PIXEL_W-1:0] nxt_data;
  // The row counter is shared: region row in TOP/BOT, active-row count across LEFT/PIX/RIGHT.
  always_comb begin
    col_max = state == PIX ? w_m : (state == LEFT || state == RIGHT) ? bw_m : rd_m;
    row_max = state == TOP ? top_m : state == RIGHT ? h_m : bot_m;
    col_en  = state == PIX ? iValid : state != IDLE;
    row_en  = state == TOP || state == RIGHT || state == BOT;
    last    = col_en && col_tc;
  end
  filter_pad_cnt u_cnt (
    .clk(clk),
    .reset(reset),
    .col_en(col_en),
    .row_en(row_en),
    .col_max(col_max),
    .row_max(row_max),
    .col_tc(col_tc),
    .row_tc(row_tc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      oValid <= 1'b0;
      oData  <= '0;
      oDone  <= 1'b0;
    end else begin
      state  <= nxt;
      oValid <= nxt_valid;
      oData  <= nxt_data;
      oDone  <= nxt_done;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = iValid ? TOP : IDLE;
      TOP:     nxt = last && row_tc ? LEFT : TOP;
      LEFT:    nxt = last ? PIX : LEFT;
      PIX:     nxt = last ? RIGHT : PIX;
      RIGHT:   nxt = last ? (row_tc ? BOT : LEFT) : RIGHT;
      BOT:     nxt = last && row_tc ? IDLE : BOT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    oReady    = state == PIX;
    nxt_valid = col_en;
    nxt_data  = state == PIX && iValid ? iData : '0;
    nxt_done  = state == BOT && last && row_tc;
  end
endmodule

// File: tb/tb_filter_pad_gen.sv
// tb_filter_pad_gen: randomized self-checking bench for the padded-frame generator (4x3, 3x3 kernel).
module tb_filter_pad_gen;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int K  = 3;
  localparam int FL = 1;
  localparam int BW = (K - 1) / 2;
  localparam int RD = W + 2 * BW;
  localparam int FR = (H + 2 * BW + FL) * RD;
  logic clk = 0, reset, iValid;
  logic [23:0] iData, oData;
  logic oReady, oValid, oDone;
  int errors = 0, checks = 0;
  int acc, cyc = 0, ready_cnt = 0;
  logic [23:0] pix [0:2*W*H-1];
  logic [23:0] q_data[$];
  bit q_done[$];
  int q_cyc[$];

  always #5 clk = ~clk;

  filter_pad_gen #(.width(W), .height(H), .kernel_size(K), .flush_rows(FL)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oDone(oDone)
  );

  always @(negedge clk) begin
    cyc++;
    if (oValid === 1'b1) begin
      q_data.push_back(oData);
      q_done.push_back(oDone);
      q_cyc.push_back(cyc);
    end
    if (oReady === 1'b1) ready_cnt++;
  end

  // Padded frame as a plain 2-D picture: active pixels sit in the centre window, everything else is 0.
  function automatic bit model_act(input int pos);
    int r = pos / RD;
    int c = pos % RD;
    return r >= BW && r < BW + H && c >= BW && c < BW + W;
  endfunction

  function automatic logic [23:0] model_px(input int f, input int pos);
    int r = pos / RD;
    int c = pos % RD;
    if (model_act(pos)) return pix[f*W*H + (r - BW)*W + (c - BW)];
    return 24'h0;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = 24'($urandom) | 24'h1;
  endtask

  task automatic clear_mon;
    @(posedge clk);
    #1;
    q_data.delete();
    q_done.delete();
    q_cyc.delete();
    ready_cnt = 0;
  endtask

  // mode 0: valid held high, 1: toggling 1,0,..., 2: random
  task automatic run_src(input int nf, input int mode, input int stop_acc);
    int total = nf * W * H;
    int budget = 0;
    bit ph = 1'b1;
    bit pend;
    acc = 0;
    @(negedge clk);
    iValid = mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
    iData = iValid ? pix[0] : 24'h0;
    pend = iValid && oReady;
    while (q_data.size() < nf * FR && !(stop_acc > 0 && acc >= stop_acc) && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (pend) acc++;
      ph = !ph;
      iValid = acc < total && (mode == 0 || (mode == 1 ? ph : $urandom_range(0, 1) == 1));
      iData = iValid ? pix[acc] : 24'h0;
      pend = iValid && oReady;
    end
    checks++;
    if (budget >= 2000) begin
      errors++;
      $display("FAIL timeout: outputs=%0d accepted=%0d within %0d cycles", q_data.size(), acc, budget);
    end
    if (stop_acc == 0) begin
      iValid = 1'b0;
      iData = 24'h0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    iValid = 1'b1;
    iData = 24'($urandom);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid: got %b want 0", oValid); end
      checks++;
      if (oReady !== 1'b0) begin errors++; $display("FAIL reset_oReady: got %b want 0", oReady); end
      checks++;
      if (oData !== 24'h0) begin errors++; $display("FAIL reset_oData: got %h want 0", oData); end
    end
    reset = 1'b0;
    iValid = 1'b0;
    iData = 24'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_continuous;
    for (int i = 0; i < W * H; i++) pix[i] = 24'(i + 1);
    clear_mon();
    run_src(1, 0, 0);
    checks++;
    if (q_data.size() != FR) begin errors++; $display("FAIL cont_count: got %0d want %0d", q_data.size(), FR); end
    for (int i = 0; i < q_data.size() && i < FR; i++) begin
      checks++;
      if (q_data[i] !== model_px(0, i)) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, q_data[i], model_px(0, i)); end
      checks++;
      if (q_done[i] !== (i == FR - 1)) begin errors++; $display("FAIL cont_done[%0d]: got %b want %b", i, q_done[i], i == FR - 1); end
      if (i > 0) begin
        checks++;
        if (q_cyc[i] - q_cyc[i-1] != 1) begin errors++; $display("FAIL cont_gap[%0d]: got %0d cycles want 1", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    checks++;
    if (acc != W * H) begin errors++; $display("FAIL cont_accepted: got %0d want %0d", acc, W * H); end
    checks++;
    if (ready_cnt != W * H) begin errors++; $display("FAIL cont_ready_cycles: got %0d want %0d", ready_cnt, W * H); end
  endtask

  task automatic test_bursty(input int mode);
    fill_random(W * H);
    clear_mon();
    run_src(1, mode, 0);
    checks++;
    if (q_data.size() != FR) begin errors++; $display("FAIL burst%0d_count: got %0d want %0d", mode, q_data.size(), FR); end
    for (int i = 0; i < q_data.size() && i < FR; i++) begin
      checks++;
      if (q_data[i] !== model_px(0, i)) begin errors++; $display("FAIL burst%0d_data[%0d]: got %h want %h", mode, i, q_data[i], model_px(0, i)); end
      checks++;
      if (q_done[i] !== (i == FR - 1)) begin errors++; $display("FAIL burst%0d_done[%0d]: got %b want %b", mode, i, q_done[i], i == FR - 1); end
      if (i > 0 && q_cyc[i] - q_cyc[i-1] > 1) begin
        checks++;
        if (!model_act(i)) begin errors++; $display("FAIL burst%0d_pad_gap[%0d]: got %0d cycles want 1", mode, i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    checks++;
    if (acc != W * H) begin errors++; $display("FAIL burst%0d_accepted: got %0d want %0d", mode, acc, W * H); end
  endtask

  task automatic test_reset_mid;
    int n;
    fill_random(W * H);
    clear_mon();
    run_src(1, 0, W + 2);
    reset = 1'b1;
    iValid = 1'b0;
    iData = 24'h0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got valid=%b ready=%b want 0 0", oValid, oReady); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = q_data.size();
    checks++;
    if (n != 2 * RD + BW + 2) begin errors++; $display("FAIL mid_abort_count: got %0d want %0d", n, 2 * RD + BW + 2); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (q_done[i] !== 1'b0 || q_data[i] !== model_px(0, i)) begin
        errors++;
        $display("FAIL mid_abort[%0d]: got %h done=%b want %h done=0", i, q_data[i], q_done[i], model_px(0, i));
      end
    end
    fill_random(W * H);
    clear_mon();
    run_src(1, 0, 0);
    checks++;
    if (q_data.size() != FR) begin errors++; $display("FAIL mid_restart_count: got %0d want %0d", q_data.size(), FR); end
    for (int i = 0; i < q_data.size() && i < FR; i++) begin
      checks++;
      if (q_data[i] !== model_px(0, i) || q_done[i] !== (i == FR - 1)) begin
        errors++;
        $display("FAIL mid_restart[%0d]: got %h done=%b want %h done=%b", i, q_data[i], q_done[i], model_px(0, i), i == FR - 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    fill_random(2 * W * H);
    clear_mon();
    run_src(2, 0, 0);
    checks++;
    if (q_data.size() != 2 * FR) begin errors++; $display("FAIL b2b_count: got %0d want %0d", q_data.size(), 2 * FR); end
    for (int i = 0; i < q_data.size() && i < 2 * FR; i++) begin
      dones += q_done[i];
      checks++;
      if (q_data[i] !== model_px(i / FR, i % FR) || q_done[i] !== (i % FR == FR - 1)) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h done=%b want %h done=%b", i, q_data[i], q_done[i], model_px(i / FR, i % FR), i % FR == FR - 1);
      end
    end
    checks++;
    if (dones != 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 2", dones); end
    if (q_cyc.size() > FR) begin
      checks++;
      if (q_cyc[FR] - q_cyc[FR-1] != 2) begin errors++; $display("FAIL b2b_restart_gap: got %0d cycles want 2", q_cyc[FR] - q_cyc[FR-1]); end
    end
  endtask

  initial begin
    iValid = 1'b0;
    iData = 24'h0;
    test_reset();
    test_continuous();
    test_bursty(1);
    test_bursty(2);
    test_reset_mid();
    test_back_to_back();
    test_bursty(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
